// File: rtl/branch_predict_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared types, opcode constants and the branch-condition
//                evaluator used by the Mini-MIPS branch predict unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

  // Branch opcodes recognised by the resolver; everything else is non-branch
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGT  = 6'b000111;
  localparam logic [5:0] OP_BLT  = 6'b001000;
  localparam logic [5:0] OP_BGE  = 6'b000110;
  localparam logic [5:0] OP_BLE  = 6'b000001;
  localparam logic [5:0] OP_BGTU = 6'b000010;
  localparam logic [5:0] OP_BLEU = 6'b000011;

  // 2-bit saturating direction counter
  typedef logic [1:0] ctr_t;
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef struct packed {
    logic is_branch;
    logic taken;
  } cond_t;

  // Operands arrive sign-extended to 64 bits. Sign extension keeps both the
  // signed and the unsigned ordering of the original XLEN-bit values, so one
  // evaluator serves any XLEN up to 64.
  function automatic cond_t branch_cond(input logic [5:0]  opcode,
                                        input logic [63:0] rs,
                                        input logic [63:0] rt);
    cond_t c;
    c = '{is_branch: 1'b1, taken: 1'b0};
    case (opcode)
      OP_BEQ:  c.taken = (rs == rt);
      OP_BNE:  c.taken = (rs != rt);
      OP_BGT:  c.taken = ($signed(rs) >  $signed(rt));
      OP_BLT:  c.taken = ($signed(rs) <  $signed(rt));
      OP_BGE:  c.taken = ($signed(rs) >= $signed(rt));
      OP_BLE:  c.taken = ($signed(rs) <= $signed(rt));
      OP_BGTU: c.taken = (rs >  rt);
      OP_BLEU: c.taken = (rs <= rt);
      default: c = '{is_branch: 1'b0, taken: 1'b0};
    endcase
    return c;
  endfunction

  // Saturating counter step: up when taken, down when not taken
  function automatic ctr_t ctr_sat(input ctr_t c, input logic up);
    if (up) begin
      return (c == ST) ? ST : c + 2'd1;
    end
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit_if
//  Description : Fetch-prediction, execute-resolve, redirect and statistics
//                signals of the branch predict unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  // Fetch-stage prediction
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  // Execute-stage branch
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [5:0]      ex_opcode;
  logic [XLEN-1:0] ex_rs_data;
  logic [XLEN-1:0] ex_rt_data;
  logic [15:0]     ex_imm;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  // Redirect to fetch and statistics
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_opcode, ex_rs_data, ex_rt_data,
           ex_imm, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect_valid, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_opcode, ex_rs_data, ex_rt_data,
           ex_imm, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect_valid, redirect_pc,
           branch_count, mispredict_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit_btb_table.sv
`default_nettype none
// ============================================================================
//  Module      : btb_table
//  Description : Direct-mapped branch target buffer with 2-bit counters.
//                One combinational lookup port for fetch, one update port
//                driven by the execute-stage resolver.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_table
  import branch_pkg::*;
#(
  parameter int   XLEN        = 32,
  parameter int   BTB_ENTRIES = 16,
  parameter int   IDX_BITS    = $clog2(BTB_ENTRIES),
  parameter ctr_t CTR_INIT    = WNT
) (
  input  wire logic            clk,
  input  wire logic            rst,
  // fetch lookup
  input  wire logic [XLEN-1:0] lookup_pc,
  output logic                 lookup_hit,
  output ctr_t                 lookup_ctr,
  output logic [XLEN-1:0]      lookup_target,
  // execute update
  input  wire logic            upd_en,
  input  wire logic [XLEN-1:0] upd_pc,
  input  wire logic            upd_is_branch,
  input  wire logic            upd_taken,
  input  wire logic [XLEN-1:0] upd_target
);

  localparam int c_tag_bits = XLEN - IDX_BITS - 2;

  logic [BTB_ENTRIES-1:0] w_valid;
  logic [c_tag_bits-1:0]  w_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        w_target [BTB_ENTRIES];
  ctr_t                   w_ctr    [BTB_ENTRIES];

  logic [IDX_BITS-1:0]    w_lk_idx;
  logic [c_tag_bits-1:0]  w_lk_tag;
  logic [IDX_BITS-1:0]    w_up_idx;
  logic [c_tag_bits-1:0]  w_up_tag;
  logic                   w_up_hit;
  logic                   w_unused;

  assign w_lk_idx = lookup_pc[IDX_BITS+1:2];
  assign w_lk_tag = lookup_pc[XLEN-1:IDX_BITS+2];
  assign w_up_idx = upd_pc[IDX_BITS+1:2];
  assign w_up_tag = upd_pc[XLEN-1:IDX_BITS+2];
  // Word-aligned PCs: the byte-offset bits never select anything
  assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Fetch lookup reads current (pre-update) contents; no write bypass
  always_comb begin
    lookup_hit    = w_valid[w_lk_idx] && (w_tag[w_lk_idx] == w_lk_tag);
    lookup_ctr    = w_ctr[w_lk_idx];
    lookup_target = w_target[w_lk_idx];
  end

  // Hit check for the entry addressed by the resolving instruction
  always_comb begin
    w_up_hit = w_valid[w_up_idx] && (w_tag[w_up_idx] == w_up_tag);
  end

  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
    logic                  r_valid;
    logic [c_tag_bits-1:0] r_tag;
    logic [XLEN-1:0]       r_target;
    ctr_t                  r_ctr;
    logic                  w_sel;

    assign w_sel = upd_en && (w_up_idx == IDX_BITS'(gi));

    // Entry state: train on hit, allocate on taken miss, drop on non-branch hit
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid  <= 1'b0;
        r_tag    <= '0;
        r_target <= '0;
        r_ctr    <= CTR_INIT;
      end else if (w_sel) begin
        if (upd_is_branch) begin
          if (w_up_hit) begin
            r_ctr <= ctr_sat(r_ctr, upd_taken);
            if (upd_taken) begin
              r_target <= upd_target;
            end
          end else if (upd_taken) begin
            r_valid  <= 1'b1;
            r_tag    <= w_up_tag;
            r_target <= upd_target;
            r_ctr    <= WT;
          end
        end else if (w_up_hit) begin
          r_valid <= 1'b0;
        end
      end
    end

    assign w_valid[gi]  = r_valid;
    assign w_tag[gi]    = r_tag;
    assign w_target[gi] = r_target;
    assign w_ctr[gi]    = r_ctr;
  end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit
//  Description : BTB-based fetch prediction plus execute-stage branch
//                resolution, registered redirect/flush and statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int   XLEN        = 32,
  parameter int   BTB_ENTRIES = 16,
  parameter int   IDX_BITS    = $clog2(BTB_ENTRIES),
  parameter ctr_t CTR_INIT    = 2'b01
) (
  input  wire logic            clk,
  input  wire logic            rst,
  branch_predict_unit_if.slave bus
);

  logic            w_lk_hit;
  ctr_t            w_lk_ctr;
  logic [XLEN-1:0] w_lk_target;
  logic [XLEN-1:0] w_fetch_plus4;

  logic [63:0]     w_rs_ext;
  logic [63:0]     w_rt_ext;
  cond_t           w_cond;
  logic [XLEN-1:0] w_ex_plus4;
  logic [XLEN-1:0] w_offset;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic            w_mispredict;

  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic [31:0]     r_branch_count;
  logic [31:0]     r_mispredict_count;

  btb_table #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES),
    .IDX_BITS    (IDX_BITS),
    .CTR_INIT    (CTR_INIT)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (bus.fetch_pc),
    .lookup_hit    (w_lk_hit),
    .lookup_ctr    (w_lk_ctr),
    .lookup_target (w_lk_target),
    .upd_en        (bus.ex_valid),
    .upd_pc        (bus.ex_pc),
    .upd_is_branch (w_cond.is_branch),
    .upd_taken     (w_cond.taken),
    .upd_target    (w_target)
  );

  // Fetch prediction: taken only on a hit with the counter in a taken state
  always_comb begin
    w_fetch_plus4   = bus.fetch_pc + XLEN'(4);
    bus.pred_taken  = w_lk_hit && w_lk_ctr[1];
    bus.pred_target = w_lk_hit ? w_lk_target : w_fetch_plus4;
  end

  // Resolve: evaluate the condition, compute the target, detect a mispredict
  always_comb begin
    w_rs_ext   = 64'($signed(bus.ex_rs_data));
    w_rt_ext   = 64'($signed(bus.ex_rt_data));
    w_cond     = branch_cond(bus.ex_opcode, w_rs_ext, w_rt_ext);
    w_ex_plus4 = bus.ex_pc + XLEN'(4);
    // {imm,00} as an 18-bit signed value is sext(imm)<<2; wrap is silent
    w_offset   = XLEN'($signed({bus.ex_imm, 2'b00}));
    w_target   = w_ex_plus4 + w_offset;
    w_next_pc  = w_cond.taken ? w_target : w_ex_plus4;
    w_mispredict = 1'b0;
    if (bus.ex_valid) begin
      if (w_cond.is_branch) begin
        w_mispredict = (w_cond.taken != bus.ex_pred_taken) ||
                       (w_cond.taken && bus.ex_pred_taken &&
                        (bus.ex_pred_target != w_target));
      end else begin
        w_mispredict = bus.ex_pred_taken;
      end
    end
  end

  // Redirect registers: one-cycle pulse, PC tracks every resolved instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      if (bus.ex_valid) begin
        r_redirect_pc <= w_next_pc;
      end
    end
  end

  // Statistics counters, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (bus.ex_valid && w_cond.is_branch) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (w_mispredict) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign bus.redirect_valid   = r_redirect_valid;
  assign bus.redirect_pc      = r_redirect_pc;
  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predict_unit
//  Description : Self-checking bench for branch_predict_unit with a
//                behavioural BTB/resolver reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_predict_unit_if #(.XLEN(32)) bus ();

  branch_predict_unit #(
    .XLEN        (32),
    .BTB_ENTRIES (16),
    .CTR_INIT    (2'b01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model (16 entries, 32-bit PC) ----------------
  bit        m_valid  [16];
  bit [31:0] m_tag    [16];
  bit [31:0] m_target [16];
  int        m_ctr    [16];
  bit [31:0] m_bcnt, m_mcnt, m_rpc;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_bcnt = 0; m_mcnt = 0; m_rpc = 0;
  endfunction

  function automatic int idx_of(bit [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit model_hit(bit [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == pc / 64);
  endfunction

  function automatic void model_predict(input bit [31:0] pc,
                                        output bit tk, output bit [31:0] tgt);
    tk  = model_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    tgt = model_hit(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  // returns {is_branch, taken}
  function automatic bit [1:0] ref_cond(bit [5:0] op, bit [31:0] rs, bit [31:0] rt);
    int signed srs, srt;
    srs = rs; srt = rt;
    case (op)
      6'b000100: return {1'b1, rs == rt};
      6'b000101: return {1'b1, rs != rt};
      6'b000111: return {1'b1, srs > srt};
      6'b001000: return {1'b1, srs < srt};
      6'b000110: return {1'b1, srs >= srt};
      6'b000001: return {1'b1, srs <= srt};
      6'b000010: return {1'b1, rs > rt};
      6'b000011: return {1'b1, rs <= rt};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic void model_resolve(input bit [5:0] op, input bit [31:0] pc,
      input bit [31:0] rs, input bit [31:0] rt, input bit [15:0] imm,
      input bit pt, input bit [31:0] ptgt, output bit rv, output bit [31:0] rpc);
    bit [1:0]    c;
    int signed   simm;
    bit [31:0]   tgt;
    int          i;
    bit          hit;
    c    = ref_cond(op, rs, rt);
    simm = $signed(imm);
    tgt  = pc + 32'd4 + 32'(simm * 4);
    rpc  = c[0] ? tgt : pc + 32'd4;
    if (c[1]) rv = (c[0] != pt) || (c[0] && pt && ptgt != tgt);
    else      rv = pt;
    i   = idx_of(pc);
    hit = model_hit(pc);
    if (c[1]) begin
      m_bcnt++;
      if (hit) begin
        m_ctr[i] = c[0] ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                        : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (c[0]) m_target[i] = tgt;
      end else if (c[0]) begin
        m_valid[i] = 1; m_tag[i] = pc / 64; m_target[i] = tgt; m_ctr[i] = 2;
      end
    end else if (hit) begin
      m_valid[i] = 0;
    end
    if (rv) m_mcnt++;
    m_rpc = rpc;
  endfunction

  task automatic drive_ex(bit v, bit [5:0] op, bit [31:0] pc, bit [31:0] rs,
                          bit [31:0] rt, bit [15:0] imm, bit pt, bit [31:0] ptgt);
    bus.ex_valid       = v;
    bus.ex_opcode      = op;
    bus.ex_pc          = pc;
    bus.ex_rs_data     = rs;
    bus.ex_rt_data     = rt;
    bus.ex_imm         = imm;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptgt;
  endtask

  // ------------------------------- tests -----------------------------------
  task automatic test_reset();
    rst = 1'b1;
    drive_ex(0, 6'd0, 0, 0, 0, 0, 0, 0);
    bus.fetch_pc = 32'h100;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %0b expected 0", bus.pred_taken); end
    n_checks++; if (bus.pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target: got %h expected 00000104", bus.pred_target); end
    n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid: got %0b expected 0", bus.redirect_valid); end
    n_checks++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h expected 0", bus.redirect_pc); end
    n_checks++; if (bus.branch_count !== 32'd0) begin n_fail++; $display("FAIL reset_branch_count: got %0d expected 0", bus.branch_count); end
    n_checks++; if (bus.mispredict_count !== 32'd0) begin n_fail++; $display("FAIL reset_mispredict_count: got %0d expected 0", bus.mispredict_count); end
  endtask

  task automatic test_alloc();
    bit rv; bit [31:0] rpc;
    @(negedge clk);
    drive_ex(1, 6'b000100, 32'h100, 5, 5, 16'h0004, 0, 0);
    model_resolve(6'b000100, 32'h100, 5, 5, 16'h0004, 0, 0, rv, rpc);
    @(posedge clk); #1;
    n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL alloc_redirect_valid: got %0b expected 1", bus.redirect_valid); end
    n_checks++; if (bus.redirect_pc !== 32'h114) begin n_fail++; $display("FAIL alloc_redirect_pc: got %h expected 00000114", bus.redirect_pc); end
    @(negedge clk);
    drive_ex(0, 6'd0, 0, 0, 0, 0, 0, 0);
    bus.fetch_pc = 32'h100;
    #1;
    n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_pred_taken: got %0b expected 1", bus.pred_taken); end
    n_checks++; if (bus.pred_target !== 32'h114) begin n_fail++; $display("FAIL alloc_pred_target: got %h expected 00000114", bus.pred_target); end
    n_checks++; if (bus.mispredict_count !== 32'd1) begin n_fail++; $display("FAIL alloc_mispredict_count: got %0d expected 1", bus.mispredict_count); end
    n_checks++; if (bus.branch_count !== 32'd1) begin n_fail++; $display("FAIL alloc_branch_count: got %0d expected 1", bus.branch_count); end
    @(posedge clk); #1;
    n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL idle_redirect_valid: got %0b expected 0", bus.redirect_valid); end
    n_checks++; if (bus.redirect_pc !== 32'h114) begin n_fail++; $display("FAIL idle_redirect_pc_hold: got %h expected 00000114", bus.redirect_pc); end
  endtask

  task automatic test_ctr_decay();
    bit rv; bit [31:0] rpc;
    bit exp_pt [3];
    bit exp_rv [2];
    exp_pt = '{1'b1, 1'b0, 1'b0};
    exp_rv = '{1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.fetch_pc = 32'h100;
      drive_ex(0, 6'd0, 0, 0, 0, 0, 0, 0);
      #1;
      n_checks++; if (bus.pred_taken !== exp_pt[k]) begin n_fail++; $display("FAIL decay_pred_taken[%0d]: got %0b expected %0b", k, bus.pred_taken, exp_pt[k]); end
      if (k < 2) begin
        drive_ex(1, 6'b000100, 32'h100, 1, 2, 16'h0004, exp_pt[k], exp_pt[k] ? 32'h114 : 32'h104);
        model_resolve(6'b000100, 32'h100, 1, 2, 16'h0004, exp_pt[k], exp_pt[k] ? 32'h114 : 32'h104, rv, rpc);
        @(posedge clk); #1;
        n_checks++; if (bus.redirect_valid !== exp_rv[k]) begin n_fail++; $display("FAIL decay_redirect_valid[%0d]: got %0b expected %0b", k, bus.redirect_valid, exp_rv[k]); end
        n_checks++; if (bus.redirect_pc !== 32'h104) begin n_fail++; $display("FAIL decay_redirect_pc[%0d]: got %h expected 00000104", k, bus.redirect_pc); end
      end
    end
  endtask

  task automatic test_signed_unsigned();
    bit rv; bit [31:0] rpc; bit pt; bit [31:0] ptgt;
    @(negedge clk);
    drive_ex(1, 6'b001000, 32'h200, 32'hFFFFFFFF, 1, 16'hFFFF, 0, 0);
    model_resolve(6'b001000, 32'h200, 32'hFFFFFFFF, 1, 16'hFFFF, 0, 0, rv, rpc);
    @(posedge clk); #1;
    n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL blt_redirect_valid: got %0b expected 1", bus.redirect_valid); end
    n_checks++; if (bus.redirect_pc !== 32'h200) begin n_fail++; $display("FAIL blt_redirect_pc: got %h expected 00000200", bus.redirect_pc); end
    @(negedge clk);
    model_predict(32'h200, pt, ptgt);
    drive_ex(1, 6'b000010, 32'h200, 32'hFFFFFFFF, 1, 16'hFFFF, pt, ptgt);
    model_resolve(6'b000010, 32'h200, 32'hFFFFFFFF, 1, 16'hFFFF, pt, ptgt, rv, rpc);
    @(posedge clk); #1;
    n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bgtu_redirect_valid: got %0b expected 0", bus.redirect_valid); end
    n_checks++; if (bus.redirect_pc !== 32'h200) begin n_fail++; $display("FAIL bgtu_redirect_pc: got %h expected 00000200", bus.redirect_pc); end
    n_checks++; if (bus.branch_count !== m_bcnt) begin n_fail++; $display("FAIL bgtu_branch_count: got %0d expected %0d", bus.branch_count, m_bcnt); end
  endtask

  task automatic test_nonbranch();
    bit rv; bit [31:0] rpc;
    @(negedge clk);
    drive_ex(1, 6'b100011, 32'h200, 3, 3, 16'h0010, 1, 32'h200);
    model_resolve(6'b100011, 32'h200, 3, 3, 16'h0010, 1, 32'h200, rv, rpc);
    @(posedge clk); #1;
    n_checks++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL nonbr_redirect_valid: got %0b expected 1", bus.redirect_valid); end
    n_checks++; if (bus.redirect_pc !== 32'h204) begin n_fail++; $display("FAIL nonbr_redirect_pc: got %h expected 00000204", bus.redirect_pc); end
    n_checks++; if (bus.branch_count !== m_bcnt) begin n_fail++; $display("FAIL nonbr_branch_count: got %0d expected %0d", bus.branch_count, m_bcnt); end
    @(negedge clk);
    drive_ex(0, 6'd0, 0, 0, 0, 0, 0, 0);
    bus.fetch_pc = 32'h200;
    #1;
    n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL nonbr_invalidated_pred: got %0b expected 0", bus.pred_taken); end
    n_checks++; if (bus.pred_target !== 32'h204) begin n_fail++; $display("FAIL nonbr_invalidated_target: got %h expected 00000204", bus.pred_target); end
  endtask

  task automatic test_random();
    bit [5:0]  ops [12];
    bit [31:0] pcs [6];
    bit        rv, v, pt, mpt;
    bit [31:0] rpc, ptgt, mtgt, pc, fpc, rs, rt;
    bit [5:0]  op;
    bit [15:0] imm;
    ops = '{6'b000100, 6'b000101, 6'b000111, 6'b001000, 6'b000110, 6'b000001,
            6'b000010, 6'b000011, 6'b000000, 6'b100011, 6'b001001, 6'b111111};
    pcs = '{32'h100, 32'h140, 32'h200, 32'h0, 32'hFFFFFFFC, 32'h1240};
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      v   = ($urandom_range(0, 99) < 85);
      op  = ops[$urandom_range(0, 11)];
      pc  = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFFFFFC) : pcs[$urandom_range(0, 5)];
      fpc = ($urandom_range(0, 1) == 0) ? pc : pcs[$urandom_range(0, 5)];
      case ($urandom_range(0, 2))
        0:       begin rs = $urandom; rt = rs; end
        1:       begin rs = 32'($urandom_range(0, 6)) - 32'd3; rt = 32'($urandom_range(0, 6)) - 32'd3; end
        default: begin rs = $urandom; rt = $urandom; end
      endcase
      imm = 16'($urandom);
      model_predict(pc, mpt, mtgt);
      if ($urandom_range(0, 9) < 7) begin pt = mpt; ptgt = mtgt; end
      else begin pt = 1'($urandom); ptgt = ($urandom_range(0, 1) == 0) ? mtgt : ($urandom & 32'hFFFFFFFC); end
      drive_ex(v, op, pc, rs, rt, imm, pt, ptgt);
      bus.fetch_pc = fpc;
      #1;
      model_predict(fpc, mpt, mtgt);
      n_checks++; if (bus.pred_taken !== mpt) begin n_fail++; $display("FAIL rnd_pred_taken it=%0d: got %0b expected %0b", it, bus.pred_taken, mpt); end
      n_checks++; if (bus.pred_target !== mtgt) begin n_fail++; $display("FAIL rnd_pred_target it=%0d: got %h expected %h", it, bus.pred_target, mtgt); end
      if (v) model_resolve(op, pc, rs, rt, imm, pt, ptgt, rv, rpc);
      else begin rv = 0; rpc = m_rpc; end
      @(posedge clk); #1;
      n_checks++; if (bus.redirect_valid !== rv) begin n_fail++; $display("FAIL rnd_redirect_valid it=%0d: got %0b expected %0b", it, bus.redirect_valid, rv); end
      n_checks++; if (bus.redirect_pc !== rpc) begin n_fail++; $display("FAIL rnd_redirect_pc it=%0d: got %h expected %h", it, bus.redirect_pc, rpc); end
      n_checks++; if (bus.branch_count !== m_bcnt) begin n_fail++; $display("FAIL rnd_branch_count it=%0d: got %0d expected %0d", it, bus.branch_count, m_bcnt); end
      n_checks++; if (bus.mispredict_count !== m_mcnt) begin n_fail++; $display("FAIL rnd_mispredict_count it=%0d: got %0d expected %0d", it, bus.mispredict_count, m_mcnt); end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    drive_ex(1, 6'b000100, 32'h300, 7, 7, 16'h0008, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_redirect_valid: got %0b expected 0", bus.redirect_valid); end
    n_checks++; if (bus.branch_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_branch_count: got %0d expected 0", bus.branch_count); end
    n_checks++; if (bus.mispredict_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_mispredict_count: got %0d expected 0", bus.mispredict_count); end
    @(negedge clk);
    rst = 1'b0;
    drive_ex(0, 6'd0, 0, 0, 0, 0, 0, 0);
    bus.fetch_pc = 32'h300;
    #1;
    n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rstmid_pred_taken: got %0b expected 0", bus.pred_taken); end
    @(posedge clk); #1;
    n_checks++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_redirect_valid: got %0b expected 0", bus.redirect_valid); end
    n_checks++; if (bus.mispredict_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_after_mispredict_count: got %0d expected 0", bus.mispredict_count); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_ctr_decay();
    test_signed_unsigned();
    test_nonbranch();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
